gate_unit: RTL and testbench

- Parametrised, registered successor to the single-bit CMOS OR cell.
- Computes a bitwise N-input logic function, selected per transaction, across WIDTH-bit operands.
- Valid/ready handshake on input and output, with a 2-entry output skid buffer so back-pressure never drops or reorders results.
- Sits between datapath producers and consumers as a generic pipelined logic stage.

---
 rtl/gate_unit_pkg.sv | 23 ++
 rtl/gate_unit_reduce.sv | 45 ++++
 rtl/gate_unit.sv | 123 ++++++++++++
 tb/tb_gate_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/gate_unit_pkg.sv
// Shared types for gate_unit: op codes, buffer states and the op field width.
package gate_unit_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_OR   = 3'd0,
        OP_NOR  = 3'd1,
        OP_AND  = 3'd2,
        OP_NAND = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_PASS = 3'd6,
        OP_NOT  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/gate_unit_reduce.sv
// Combinational bitwise N_IN-operand logic function selected by op.
module gate_unit_reduce
    import gate_unit_pkg::*;
#(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic [OP_W-1:0]       op,
    input  logic [N_IN*WIDTH-1:0] a,
    output logic [WIDTH-1:0]      result
);

    logic [WIDTH-1:0] acc_or;
    logic [WIDTH-1:0] acc_and;
    logic [WIDTH-1:0] acc_xor;
    logic [WIDTH-1:0] opnd0;

    always_comb begin
        acc_or  = '0;
        acc_and = '1;
        acc_xor = '0;
        opnd0   = a[WIDTH-1:0];
        for (int i = 0; i < int'(N_IN); i++) begin
            acc_or  = acc_or  | a[i*WIDTH +: WIDTH];
            acc_and = acc_and & a[i*WIDTH +: WIDTH];
            acc_xor = acc_xor ^ a[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        result = '0;
        case (op_e'(op))
            OP_OR:   result = acc_or;
            OP_NOR:  result = ~acc_or;
            OP_AND:  result = acc_and;
            OP_NAND: result = ~acc_and;
            OP_XOR:  result = acc_xor;
            OP_XNOR: result = ~acc_xor;
            OP_PASS: result = opnd0;
            OP_NOT:  result = ~opnd0;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/gate_unit.sv
// Registered N-input logic stage with valid/ready handshake and 2-entry skid buffer.
// Optional GATE_UNIT_PARITY_EN adds a per-entry even-parity output y_par.
module gate_unit
    import gate_unit_pkg::*;
#(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_W-1:0]       op,
    input  logic [N_IN*WIDTH-1:0] a,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      y
`ifdef GATE_UNIT_PARITY_EN
    ,
    output logic                  y_par
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [WIDTH-1:0] res;
    logic             push;
    logic             pop;
`ifdef GATE_UNIT_PARITY_EN
    logic             head_par_q, head_par_d;
    logic             tail_par_q, tail_par_d;
    logic             res_par;
`endif

    gate_unit_reduce #(
        .N_IN  (N_IN),
        .WIDTH (WIDTH)
    ) u_reduce (
        .op     (op),
        .a      (a),
        .result (res)
    );

    // Ready depends on state only, so no path from out_ready to in_ready.
    assign in_ready  = rst_n && (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign y         = head_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
`ifdef GATE_UNIT_PARITY_EN
    assign res_par   = ^res;
    assign y_par     = head_par_q;
`endif

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
`ifdef GATE_UNIT_PARITY_EN
        head_par_d = head_par_q;
        tail_par_d = tail_par_q;
`endif
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    head_d  = res;
`ifdef GATE_UNIT_PARITY_EN
                    head_par_d = res_par;
`endif
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = res;
`ifdef GATE_UNIT_PARITY_EN
                    head_par_d = res_par;
`endif
                end else if (push) begin
                    state_d = TWO;
                    tail_d  = res;
`ifdef GATE_UNIT_PARITY_EN
                    tail_par_d = res_par;
`endif
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = tail_q;
`ifdef GATE_UNIT_PARITY_EN
                    head_par_d = tail_par_q;
`endif
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
`ifdef GATE_UNIT_PARITY_EN
            head_par_q <= 1'b0;
            tail_par_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
`ifdef GATE_UNIT_PARITY_EN
            head_par_q <= head_par_d;
            tail_par_q <= tail_par_d;
`endif
        end
    end

endmodule

// File: tb/tb_gate_unit.sv
// Directed bench for gate_unit: a 4x8 instance and a 2x1 scalar instance.
module tb_gate_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [7:0]  y;
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [2:0]  s_op;
    logic [1:0]  s_a;
    logic        s_y;
`ifdef GATE_UNIT_PARITY_EN
    logic        y_par, s_y_par;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gate_unit #(.N_IN(4), .WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .out_valid(out_valid), .out_ready(out_ready), .y(y)
`ifdef GATE_UNIT_PARITY_EN
        , .y_par(y_par)
`endif
    );

    gate_unit #(.N_IN(2), .WIDTH(1)) u_sc (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op(s_op), .a(s_a), .out_valid(s_out_valid), .out_ready(s_out_ready), .y(s_y)
`ifdef GATE_UNIT_PARITY_EN
        , .y_par(s_y_par)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-bit count of ones across operands, independent of how the DUT reduces.
    function automatic logic [7:0] ref_fn(input logic [2:0] f, input logic [31:0] v);
        logic [7:0] r;
        int cnt;
        r = 8'h00;
        for (int b = 0; b < 8; b++) begin
            cnt = 0;
            for (int k = 0; k < 4; k++) cnt += int'(v[k*8 + b]);
            case (f)
                3'd0: r[b] = (cnt != 0);
                3'd1: r[b] = (cnt == 0);
                3'd2: r[b] = (cnt == 4);
                3'd3: r[b] = (cnt != 4);
                3'd4: r[b] = (cnt % 2 == 1);
                3'd5: r[b] = (cnt % 2 == 0);
                3'd6: r[b] = v[b];
                default: r[b] = ~v[b];
            endcase
        end
        return r;
    endfunction

    initial begin
        logic [7:0]  op_exp [8];
        logic [3:0]  sc_exp;
        logic [7:0]  exp_y;

        op_exp[0] = 8'hFF; op_exp[1] = 8'h00; op_exp[2] = 8'h01; op_exp[3] = 8'hFE;
        op_exp[4] = 8'h96; op_exp[5] = 8'h69; op_exp[6] = 8'h0F; op_exp[7] = 8'hF0;
        sc_exp = 4'b1110;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; a = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_op = 3'd0; s_a = 2'b00;

        // Reset and idle
        #1;
        check("rst_in_ready_pre", 32'(in_ready), 32'd0);
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'h00);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // All ops streaming with out_ready high
        out_ready = 1'b1;
        a = {8'hFF, 8'h55, 8'h33, 8'h0F};
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            in_valid = 1'b1;
            step();
            check($sformatf("op%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("op%0d_y", i), 32'(y), 32'(op_exp[i]));
`ifdef GATE_UNIT_PARITY_EN
            check($sformatf("op%0d_par", i), 32'(y_par), 32'(^op_exp[i]));
`endif
        end
        in_valid = 1'b0;
        step();
        check("ops_drain_valid", 32'(out_valid), 32'd0);

        // Back-pressure
        out_ready = 1'b0;
        op = 3'd0;
        a = {8'h00, 8'h00, 8'h00, 8'h11};
        in_valid = 1'b1;
        step();
        check("bp_first_y", 32'(y), 32'h11);
        check("bp_first_in_ready", 32'(in_ready), 32'd1);
        a = {8'h00, 8'h00, 8'h20, 8'h02};
        step();
        in_valid = 1'b0;
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        check("bp_full_y", 32'(y), 32'h11);
        step();
        check("bp_hold_y", 32'(y), 32'h11);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        check("bp_pop1_y", 32'(y), 32'h22);
        check("bp_pop1_in_ready", 32'(in_ready), 32'd1);
        check("bp_pop1_valid", 32'(out_valid), 32'd1);
        step();
        check("bp_pop2_valid", 32'(out_valid), 32'd0);

        // Random streaming: push and pop together in ONE every cycle
        for (int i = 0; i < 100; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            in_valid = 1'b1;
            exp_y = ref_fn(op, a);
            step();
            check($sformatf("str%0d_y", i), 32'(y), 32'(exp_y));
            check($sformatf("str%0d_flow", i), {30'd0, out_valid, in_ready}, 32'd3);
`ifdef GATE_UNIT_PARITY_EN
            check($sformatf("str%0d_par", i), 32'(y_par), 32'(^exp_y));
`endif
        end
        in_valid = 1'b0;
        step();

        // Reset with the buffer full
        out_ready = 1'b0;
        op = 3'd2;
        a = {8'hFF, 8'hFF, 8'hFF, 8'hC3};
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        check("mid_full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_y", 32'(y), 32'h00);
        rst_n = 1'b1;
        op = 3'd0;
        a = {8'h50, 8'h00, 8'h0A, 8'h00};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("mid_fresh_y", 32'(y), 32'h5A);
        out_ready = 1'b1;
        step();
        check("mid_no_stale", 32'(out_valid), 32'd0);

        // Scalar configuration, OR over all input combinations
        s_out_ready = 1'b1;
        s_op = 3'd0;
        for (int i = 0; i < 4; i++) begin
            s_a = 2'(i);
            s_in_valid = 1'b1;
            step();
            check($sformatf("sc%0d_valid", i), 32'(s_out_valid), 32'd1);
            check($sformatf("sc%0d_y", i), 32'(s_y), 32'(sc_exp[i]));
`ifdef GATE_UNIT_PARITY_EN
            check($sformatf("sc%0d_par", i), 32'(s_y_par), 32'(sc_exp[i]));
`endif
        end
        s_in_valid = 1'b0;
        step();
        check("sc_drain_valid", 32'(s_out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
